io_input_cond: RTL

Input conditioner between the board switch/button pins and the CPU's `i_io_sw` / `i_io_btn` inputs, which the LSU input memory samples. It synchronizes all inputs into the `i_clk` domain. Each button is debounced by its own counter-based state machine. Software reads the results as clean levels, one-cycle press pulses and sticky press flags.

---
 rtl/io_input_cond_pkg.sv | 15 +
 rtl/io_input_cond_if.sv | 27 ++
 rtl/io_input_cond_btn_debounce.sv | 114 +++++++++++
 rtl/io_input_cond.sv | 52 +++++
 4 files changed

// File: rtl/io_input_cond_pkg.sv
// Shared types and default sizes for the board input conditioner.
package io_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int IO_SW_W             = 32;
  localparam int IO_BTN_W            = 4;
  localparam int IO_DEBOUNCE_DEFAULT = 500000;

endpackage

// File: rtl/io_input_cond_if.sv
// Pin-side bundle of the input conditioner: raw pins and clears in, clean levels and press events out.
interface io_input_cond_if
  import io_cond_pkg::*;
#(
  parameter int SW_W  = IO_SW_W,
  parameter int BTN_W = IO_BTN_W
);

  logic [SW_W-1:0]  i_sw_raw;
  logic [BTN_W-1:0] i_btn_raw;
  logic [BTN_W-1:0] i_btn_clr;
  logic [SW_W-1:0]  o_io_sw;
  logic [BTN_W-1:0] o_io_btn;
  logic [BTN_W-1:0] o_btn_press;
  logic [BTN_W-1:0] o_btn_sticky;

  modport master (
    output i_sw_raw, i_btn_raw, i_btn_clr,
    input  o_io_sw, o_io_btn, o_btn_press, o_btn_sticky
  );

  modport slave (
    input  i_sw_raw, i_btn_raw, i_btn_clr,
    output o_io_sw, o_io_btn, o_btn_press, o_btn_sticky
  );

endinterface

// File: rtl/io_input_cond_btn_debounce.sv
// One button: polarity fix, 2-flop synchronizer, counter-based debounce FSM and sticky press flag.
module btn_debounce
  import io_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  input  logic i_clr,
  output logic o_level,
  output logic o_press,
  output logic o_sticky
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  logic             raw_act;
  logic             sync_meta;
  logic             s;
  btn_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // Inverting ahead of the synchronizer keeps every flop's reset value equal to "not pressed".
  assign raw_act = ACTIVE_LOW ? ~i_raw : i_raw;
  assign cnt_inc = (cnt < CNT_MAX) ? cnt + CNT_ONE : cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_meta <= 1'b0;
      s         <= 1'b0;
    end else begin
      sync_meta <= raw_act;
      s         <= sync_meta;
    end
  end

  // Level and press are registered alongside the state so they change on the accepting edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= RELEASED;
      cnt     <= '0;
      o_level <= 1'b0;
      o_press <= 1'b0;
    end else begin
      o_press <= 1'b0;
      case (state)
        RELEASED: begin
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= PRESSED;
            cnt     <= '0;
            o_level <= 1'b1;
            o_press <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= RELEASED;
            cnt     <= '0;
            o_level <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state   <= RELEASED;
          cnt     <= '0;
          o_level <= 1'b0;
        end
      endcase
    end
  end

  // A press landing on the same edge as a clear must not be lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sticky <= 1'b0;
    end else if (o_press) begin
      o_sticky <= 1'b1;
    end else if (i_clr) begin
      o_sticky <= 1'b0;
    end
  end

endmodule

// File: rtl/io_input_cond.sv
// Conditions board switches and buttons into clean i_clk-domain signals for the CPU input memory.
module io_input_cond
  import io_cond_pkg::*;
#(
  parameter int SW_W            = IO_SW_W,
  parameter int BTN_W           = IO_BTN_W,
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  io_input_cond_if.slave bus
);

  logic [SW_W-1:0]  sw_meta;
  logic [SW_W-1:0]  sw_sync;
  logic [BTN_W-1:0] btn_level;
  logic [BTN_W-1:0] btn_press;
  logic [BTN_W-1:0] btn_sticky;

  // Switches are treated as slow levels: synchronize only, software tolerates bounce.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= bus.i_sw_raw;
      sw_sync <= sw_meta;
    end
  end

  for (genvar g = 0; g < BTN_W; g++) begin : gen_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (BTN_ACTIVE_LOW)
    ) u_btn (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_raw   (bus.i_btn_raw[g]),
      .i_clr   (bus.i_btn_clr[g]),
      .o_level (btn_level[g]),
      .o_press (btn_press[g]),
      .o_sticky(btn_sticky[g])
    );
  end

  assign bus.o_io_sw      = sw_sync;
  assign bus.o_io_btn     = btn_level;
  assign bus.o_btn_press  = btn_press;
  assign bus.o_btn_sticky = btn_sticky;

endmodule
